oscillator_period_meter: RTL and testbench

//  Measures oscillator period: counts CLK cycles spanning 2^AVG_SHIFT rising edges of async FREQ_IN.

---
 rtl/period_meter_pkg.sv | 13 +
 rtl/signal_sync_edge.sv | 47 ++++
 rtl/oscillator_period_meter.sv | 115 +++++++++++
 tb/tb_oscillator_period_meter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/period_meter_pkg.sv
// Shared types and constants for the oscillator period meter.
package period_meter_pkg;

  typedef enum logic {ST_ALIGN, ST_MEASURE} meter_state_t;

  // Consecutive synced samples required on each side of an accepted edge
  localparam int unsigned DEGLITCH_LEN = 2;

  function automatic int unsigned edge_cnt_width(input int unsigned avg_shift);
    return (avg_shift == 0) ? 1 : avg_shift;
  endfunction

endpackage

// File: rtl/signal_sync_edge.sv
// FREQ_IN synchronizer and rising-edge detector.
// PERIOD_METER_DEGLITCH_EN: require DEGLITCH_LEN lows then DEGLITCH_LEN highs.
module signal_sync_edge
  import period_meter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic CE,
  input  logic ASYNC_IN,
  output logic EDGE_OUT
);

`ifdef PERIOD_METER_DEGLITCH_EN
  localparam int unsigned RUN = DEGLITCH_LEN;
`else
  localparam int unsigned RUN = 1;
`endif
  localparam int unsigned WIN   = 2 * RUN;
  localparam int unsigned HIST  = WIN - 1;
  localparam int unsigned DEPTH = SYNC_STAGES + HIST;
  localparam logic [WIN-1:0] PATTERN = WIN'((2 ** RUN) - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [HIST-1:0]        r_hist;
  logic [DEPTH-1:0]       r_vld;
  logic [WIN-1:0]         w_win;

  // r_vld marks stages holding post-reset samples, so a level that was high
  // through reset release never looks like a rise.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sync <= '0;
      r_hist <= '0;
      r_vld  <= '0;
    end else if (CE) begin
      r_sync <= SYNC_STAGES'({r_sync, ASYNC_IN});
      r_hist <= HIST'({r_hist, r_sync[SYNC_STAGES-1]});
      r_vld  <= DEPTH'({r_vld, 1'b1});
    end
  end

  assign w_win    = {r_hist, r_sync[SYNC_STAGES-1]};
  assign EDGE_OUT = r_vld[DEPTH-1] && (w_win == PATTERN);

endmodule

// File: rtl/oscillator_period_meter.sv
// Counts CLK cycles spanning 2^AVG_SHIFT FREQ_IN periods, windows back to back.
// Optional PERIOD_METER_DEGLITCH_EN filters single-cycle FREQ_IN pulses.
module oscillator_period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned OUT_DATA_BITS  = 32,
  parameter int unsigned AVG_SHIFT      = 4,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 2 ** 20
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            CE,
  input  logic                            FREQ_IN,
  output logic signed [OUT_DATA_BITS-1:0] PERIOD_VALUE,
  output logic                            PERIOD_VALID,
  output logic                            TIMEOUT
);

  localparam int unsigned CW = OUT_DATA_BITS - 1;
  localparam int unsigned EW = edge_cnt_width(AVG_SHIFT);
  localparam logic [EW-1:0] EDGE_LAST = EW'((2 ** AVG_SHIFT) - 1);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES);

  meter_state_t  r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [EW-1:0] r_edge_cnt, w_edge_cnt_nxt;
  logic [CW-1:0] r_period, w_period_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_timeout, w_timeout_nxt;
  logic          w_edge, w_close, w_expire;

  signal_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .CLK     (CLK),
    .RESET   (RESET),
    .CE      (CE),
    .ASYNC_IN(FREQ_IN),
    .EDGE_OUT(w_edge)
  );

  always_ff @(posedge CLK) begin
    if (RESET)   r_state <= ST_ALIGN;
    else if (CE) r_state <= w_state_nxt;
  end

  // >= rather than == keeps cnt bounded when a non-closing edge lands on the limit
  always_comb begin
    w_close     = (r_state == ST_MEASURE) && w_edge && (r_edge_cnt == EDGE_LAST);
    w_expire    = (r_state == ST_MEASURE) && !w_edge && (r_cnt >= CNT_LIMIT);
    w_state_nxt = r_state;
    case (r_state)
      ST_ALIGN:   if (w_edge)   w_state_nxt = ST_MEASURE;
      ST_MEASURE: if (w_expire) w_state_nxt = ST_ALIGN;
      default:    w_state_nxt = ST_ALIGN;
    endcase
  end

  always_comb begin
    w_cnt_nxt      = r_cnt;
    w_edge_cnt_nxt = r_edge_cnt;
    w_period_nxt   = r_period;
    w_valid_nxt    = 1'b0;
    w_timeout_nxt  = r_timeout;
    case (r_state)
      ST_ALIGN: begin
        if (w_edge) begin
          w_cnt_nxt      = CW'(1);
          w_edge_cnt_nxt = '0;
        end
      end
      ST_MEASURE: begin
        if (w_close) begin
          w_period_nxt   = r_cnt;
          w_valid_nxt    = 1'b1;
          w_timeout_nxt  = 1'b0;
          w_cnt_nxt      = CW'(1);
          w_edge_cnt_nxt = '0;
        end else if (w_edge) begin
          w_edge_cnt_nxt = r_edge_cnt + 1'b1;
          w_cnt_nxt      = r_cnt + 1'b1;
        end else if (w_expire) begin
          w_timeout_nxt  = 1'b1;
          w_cnt_nxt      = '0;
        end else begin
          w_cnt_nxt      = r_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cnt      <= '0;
      r_edge_cnt <= '0;
      r_period   <= '0;
      r_valid    <= 1'b0;
      r_timeout  <= 1'b0;
    end else if (CE) begin
      r_cnt      <= w_cnt_nxt;
      r_edge_cnt <= w_edge_cnt_nxt;
      r_period   <= w_period_nxt;
      r_valid    <= w_valid_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  // A strobe pending across a CE=0 stretch is held and shown once CE returns
  assign PERIOD_VALUE = $signed({1'b0, r_period});
  assign PERIOD_VALID = r_valid & CE;
  assign TIMEOUT      = r_timeout;

endmodule

// File: tb/tb_oscillator_period_meter.sv
// Bench for oscillator_period_meter: timestamp-based reference model plus literal pins.
module tb_oscillator_period_meter;

  localparam int OUT_DATA_BITS  = 32;
  localparam int AVG_SHIFT      = 4;
  localparam int SYNC_STAGES    = 2;
  localparam int TIMEOUT_CYCLES = 5000;
  localparam int NWIN           = 1 << AVG_SHIFT;
`ifdef PERIOD_METER_DEGLITCH_EN
  localparam int RUN = 2;
  localparam longint GLITCH_EXP = 640;
`else
  localparam int RUN = 1;
  localparam longint GLITCH_EXP = 320;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b1;
  logic fin = 1'b1;
  logic signed [OUT_DATA_BITS-1:0] period_value;
  logic period_valid;
  logic timeout;

  always #5 clk = ~clk;

  oscillator_period_meter #(
    .OUT_DATA_BITS (OUT_DATA_BITS),
    .AVG_SHIFT     (AVG_SHIFT),
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .CLK         (clk),
    .RESET       (rst),
    .CE          (ce),
    .FREQ_IN     (fin),
    .PERIOD_VALUE(period_value),
    .PERIOD_VALID(period_valid),
    .TIMEOUT     (timeout)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: synced level is FREQ_IN delayed by SYNC_STAGES active
  // samples; a window is the span between edge timestamps 0 and NWIN.
  bit     hq[$];
  longint t_now = 0;
  longint t_open = 0;
  int     ecount = 0;
  bit     aligned = 0;
  longint m_val = 0;
  bit     m_pend = 0;
  bit     m_to = 0;
  bit     s_rst, s_ce, s_fin, s_edge;
  int     strobe_cnt = 0;
  longint last_val = 0;

  function automatic bit edge_seen();
    int n    = hq.size();
    int k    = 2 * RUN;
    int last = n - SYNC_STAGES;
    if (last - (k - 1) < 0) return 1'b0;
    for (int j = 0; j < k; j++)
      if (hq[last - k + 1 + j] != (j >= RUN)) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    s_rst = rst;
    s_ce  = ce;
    s_fin = fin;
    if (s_rst) begin
      hq.delete();
      aligned = 0;
      m_val   = 0;
      m_pend  = 0;
      m_to    = 0;
    end else if (s_ce) begin
      s_edge = edge_seen();
      t_now++;
      m_pend = 0;
      if (!aligned) begin
        if (s_edge) begin
          aligned = 1;
          t_open  = t_now;
          ecount  = 0;
        end
      end else if (s_edge) begin
        ecount++;
        if (ecount == NWIN) begin
          m_val  = t_now - t_open;
          m_pend = 1;
          m_to   = 0;
          t_open = t_now;
          ecount = 0;
        end
      end else if (t_now - t_open >= TIMEOUT_CYCLES) begin
        m_to    = 1;
        aligned = 0;
      end
      hq.push_back(s_fin);
      if (hq.size() > 64) void'(hq.pop_front());
    end
    #1;
    check("valid", period_valid, m_pend & ce);
    check("value", period_value, m_val);
    check("timeout", timeout, m_to);
    if (period_valid) begin
      strobe_cnt++;
      last_val = period_value;
    end
  end

  int phase = 0;

  task automatic run(input int cycles, input int period, input bit glitch);
    repeat (cycles) begin
      @(negedge clk);
      phase = (phase + 1 >= period) ? 0 : phase + 1;
      fin = (phase < period / 2) || (glitch && phase == (period * 3) / 4);
    end
  endtask

  task automatic hold(input int cycles, input bit level);
    repeat (cycles) begin
      @(negedge clk);
      fin = level;
    end
  endtask

  int snap;

  initial begin
    // FREQ_IN high across reset release must not produce an edge
    repeat (4) @(negedge clk);
    rst = 1'b0;
    hold(30, 1'b1);
    hold(20, 1'b0);

    // Steady period 40
    phase = 39;
    strobe_cnt = 0;
    run(4 * 640 + 100, 40, 1'b0);
    check("s1_strobes", strobe_cnt, 4);
    check("s1_value", last_val, 640);

    // Period changes to 39 mid-window
    run(20, 40, 1'b0);
    run(4 * 624, 39, 1'b0);
    check("s2_value", last_val, 624);

    // Oscillator lost, then restarted
    hold(10, 1'b0);
    snap = strobe_cnt;
    hold(5200, 1'b0);
    check("s3_timeout", timeout, 1);
    check("s3_no_strobe", strobe_cnt, snap);
    phase = 39;
    run(16 * 40 + 60, 40, 1'b0);
    check("s3_restart_strobes", strobe_cnt, snap + 1);
    check("s3_timeout_clr", timeout, 0);
    check("s3_value", last_val, 640);

    // Reset mid-window
    run(300, 40, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2;
    check("s4_rst_value", period_value, 0);
    check("s4_rst_valid", period_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    run(2 * 640 + 100, 40, 1'b0);
    check("s4_value", last_val, 640);

    // CE low for 100 cycles mid-window
    run(300, 40, 1'b0);
    snap = strobe_cnt;
    @(negedge clk);
    ce = 1'b0;
    run(100, 40, 1'b0);
    check("s5_no_strobe", strobe_cnt, snap);
    ce = 1'b1;
    run(3 * 640, 40, 1'b0);
    check("s5_value", last_val, 640);

    // Single-cycle pulses in the low phase
    run(3 * 640 + 100, 40, 1'b1);
    check("s6_glitch_value", last_val, GLITCH_EXP);

    // Random segments: period, glitches, CE drops, occasional reset
    for (int s = 0; s < 40; s++) begin
      int p   = int'($urandom_range(8, 60));
      int len = int'($urandom_range(50, 600));
      bit g   = 1'(($urandom_range(0, 3)) == 0);
      for (int c = 0; c < len; c++) begin
        run(1, p, g);
        ce  = ($urandom_range(0, 19) != 0);
        rst = ($urandom_range(0, 4999) == 0);
      end
      ce  = 1'b1;
      rst = 1'b0;
    end
    run(700, 40, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
